// File: rtl/rr_grant_burst_mux.sv
// Burst mux behind the 3-way round-robin arbiter: latches the granted requester
// as owner and streams len+1 beats from its lane over one valid/ready channel.
module rr_grant_burst_mux #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int LW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    get,
  input  logic [N*LW-1:0] req_len,
  input  logic [N*DW-1:0] req_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_src,
  output logic            out_last,
  output logic [N-1:0]    data_ack,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            err
);

  // Handshake: a beat transfers on every cycle where out_valid && out_ready;
  // out_valid, out_data, out_src and out_last hold steady while out_ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_cnt;

  logic          grant_one;
  logic          grant_multi;
  logic [1:0]    grant_idx;
  logic [LW-1:0] cap_len;
  logic [DW-1:0] lane_data;
  logic [N-1:0]  owner_hot;
  logic          accept;
  logic          last_beat;

  always_comb begin
    grant_one   = 1'b0;
    grant_multi = 1'b0;
    grant_idx   = 2'd0;
    case (get)
      3'b000: ;
      3'b001: begin grant_one = 1'b1; grant_idx = 2'd0; end
      3'b010: begin grant_one = 1'b1; grant_idx = 2'd1; end
      3'b100: begin grant_one = 1'b1; grant_idx = 2'd2; end
      default: grant_multi = 1'b1;
    endcase
  end

  // Lane selection: capture length by incoming grant, stream data by latched owner.
  always_comb begin
    cap_len   = '0;
    lane_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == 2'(i)) cap_len = req_len[i*LW +: LW];
      if (owner == 2'(i))     lane_data = req_data[i*DW +: DW];
    end
  end

  assign owner_hot = {{(N-1){1'b0}}, 1'b1} << owner;
  assign last_beat = (beat_cnt == len_q);
  assign accept    = (state == XFER) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      len_q    <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_one) begin
            owner    <= grant_idx;
            len_q    <= cap_len;
            beat_cnt <= '0;
            state    <= XFER;
          end else if (grant_multi) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          // The final beat leaves the counter alone so len 2^LW-1 cannot wrap.
          if (accept) begin
            if (last_beat) state <= DONE;
            else           beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == XFER);
  assign busy      = (state != IDLE);
  assign out_last  = out_valid && last_beat;
  assign out_data  = out_valid ? lane_data : '0;
  assign out_src   = out_valid ? owner : 2'd0;
  assign data_ack  = accept ? owner_hot : '0;
  assign done      = (state == DONE) ? owner_hot : '0;

endmodule

// File: tb/tb_rr_grant_burst_mux.sv
// Self-checking bench for rr_grant_burst_mux: directed scenarios plus randomized
// bursts checked against a beat-counting model of the channel.
module tb_rr_grant_burst_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  get;
  logic [11:0] req_len;
  logic [23:0] req_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic [2:0]  data_ack;
  logic [2:0]  done;
  logic        busy;
  logic        err;

  logic [7:0]  lane_val[3];
  logic [3:0]  len_val[3];
  logic [19:0] obs;
  logic [19:0] exp_v;
  int          checks = 0;
  int          passes = 0;

  rr_grant_burst_mux dut (
    .clk(clk), .rst(rst), .get(get), .req_len(req_len), .req_data(req_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .data_ack(data_ack), .done(done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = {lane_val[2], lane_val[1], lane_val[0]};
    req_len  = {len_val[2], len_val[1], len_val[0]};
  end

  assign obs = {busy, out_valid, out_last, out_src, out_data, data_ack, done, err};

  function automatic logic [19:0] mk(input logic b, input logic v, input logic l,
                                     input logic [1:0] s, input logic [7:0] d,
                                     input logic [2:0] a, input logic [2:0] dn,
                                     input logic e);
    return {b, v, l, s, d, a, dn, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; get = 3'b000; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin lane_val[i] = 8'($urandom); len_val[i] = 4'($urandom); end
    tick(); tick(); smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL reset_held: got %h expected %h", obs, exp_v); else passes++;
    tick(); rst = 1'b0; smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL reset_release: got %h expected %h", obs, exp_v); else passes++;
    tick();
  endtask

  task automatic test_single_beat();
    lane_val[0] = 8'hA5; len_val[0] = 4'd0; out_ready = 1'b1; get = 3'b001;
    smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL single_idle: got %h expected %h", obs, exp_v); else passes++;
    tick(); get = 3'b000; smp();
    exp_v = mk(1,1,1,2'd0,8'hA5,3'b001,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL single_beat: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(1,0,0,2'd0,8'h00,3'b000,3'b001,0); checks++;
    if (obs !== exp_v) $display("FAIL single_done: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL single_after: got %h expected %h", obs, exp_v); else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    logic pat[7];
    int acc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    lane_val[2] = 8'h10; len_val[2] = 4'd3; out_ready = 1'b0; get = 3'b100;
    acc = 0;
    smp();
    tick(); get = 3'b000;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        tick();
        if (pat[k-1]) lane_val[2] = lane_val[2] + 8'd1;
      end
      out_ready = pat[k];
      smp();
      exp_v = mk(1,1,(acc == 3),2'd2,lane_val[2],pat[k] ? 3'b100 : 3'b000,3'b000,0); checks++;
      if (obs !== exp_v) $display("FAIL backpressure_cyc%0d: got %h expected %h", k, obs, exp_v); else passes++;
      if (pat[k]) acc++;
    end
    tick(); out_ready = 1'b0; smp();
    exp_v = mk(1,0,0,2'd0,8'h00,3'b000,3'b100,0); checks++;
    if (obs !== exp_v) $display("FAIL backpressure_done: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL backpressure_idle: got %h expected %h", obs, exp_v); else passes++;
    tick();
  endtask

  task automatic test_rotation();
    logic [2:0] hot;
    for (int r = 0; r < 3; r++) begin
      hot = 3'b001 << r;
      lane_val[r] = 8'(8'h30 + r * 16); len_val[r] = 4'd1; out_ready = 1'b1; get = hot;
      smp();
      exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
      if (obs !== exp_v) $display("FAIL rotation_idle%0d: got %h expected %h", r, obs, exp_v); else passes++;
      for (int b = 0; b < 2; b++) begin
        tick(); get = 3'b000;
        if (b == 1) lane_val[r] = lane_val[r] + 8'd1;
        smp();
        exp_v = mk(1,1,(b == 1),2'(r),lane_val[r],hot,3'b000,0); checks++;
        if (obs !== exp_v) $display("FAIL rotation_beat%0d_%0d: got %h expected %h", r, b, obs, exp_v); else passes++;
      end
      tick(); smp();
      exp_v = mk(1,0,0,2'd0,8'h00,3'b000,hot,0); checks++;
      if (obs !== exp_v) $display("FAIL rotation_done%0d: got %h expected %h", r, obs, exp_v); else passes++;
      tick();
    end
  endtask

  task automatic test_grant_change();
    lane_val[1] = 8'h55; len_val[1] = 4'd2; lane_val[0] = 8'h66; len_val[0] = 4'd0;
    out_ready = 1'b1; get = 3'b010;
    smp();
    for (int b = 0; b < 3; b++) begin
      tick(); get = 3'b001;
      if (b > 0) lane_val[1] = lane_val[1] + 8'd1;
      smp();
      exp_v = mk(1,1,(b == 2),2'd1,lane_val[1],3'b010,3'b000,0); checks++;
      if (obs !== exp_v) $display("FAIL change_beat%0d: got %h expected %h", b, obs, exp_v); else passes++;
    end
    tick(); smp();
    exp_v = mk(1,0,0,2'd0,8'h00,3'b000,3'b010,0); checks++;
    if (obs !== exp_v) $display("FAIL change_done: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL change_gap: got %h expected %h", obs, exp_v); else passes++;
    tick(); get = 3'b000; smp();
    exp_v = mk(1,1,1,2'd0,8'h66,3'b001,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL change_next_beat: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(1,0,0,2'd0,8'h00,3'b000,3'b001,0); checks++;
    if (obs !== exp_v) $display("FAIL change_next_done: got %h expected %h", obs, exp_v); else passes++;
    tick();
  endtask

  task automatic test_illegal();
    get = 3'b101; out_ready = 1'b1;
    smp();
    tick(); get = 3'b000; smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,1); checks++;
    if (obs !== exp_v) $display("FAIL illegal_err: got %h expected %h", obs, exp_v); else passes++;
    tick(); smp();
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL illegal_clear: got %h expected %h", obs, exp_v); else passes++;
    tick();
  endtask

  task automatic test_async_reset();
    lane_val[1] = 8'h77; len_val[1] = 4'd3; out_ready = 1'b1; get = 3'b010;
    smp();
    tick(); get = 3'b000; smp();
    exp_v = mk(1,1,0,2'd1,8'h77,3'b010,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL areset_beat1: got %h expected %h", obs, exp_v); else passes++;
    tick(); lane_val[1] = 8'h78;
    #2; rst = 1'b1; #1;
    exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
    if (obs !== exp_v) $display("FAIL areset_immediate: got %h expected %h", obs, exp_v); else passes++;
    tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      smp();
      exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
      if (obs !== exp_v) $display("FAIL areset_after%0d: got %h expected %h", c, obs, exp_v); else passes++;
      tick();
    end
  endtask

  // Model: a burst is len+1 accepted beats from the owner's lane; the cycle
  // after the final acceptance carries done, and grants are captured only when idle.
  task automatic test_random();
    int r, len, acc, cyc;
    logic [2:0] hot;
    logic accepted;
    for (int b = 0; b < 40; b++) begin
      r = $urandom_range(0, 2);
      len = (b % 8 == 0) ? 15 : (b % 8 == 1) ? 0 : $urandom_range(0, 15);
      hot = 3'b001 << r;
      for (int i = 0; i < 3; i++) begin lane_val[i] = 8'($urandom); len_val[i] = 4'($urandom); end
      len_val[r] = 4'(len); get = hot; out_ready = 1'($urandom);
      smp();
      exp_v = mk(0,0,0,2'd0,8'h00,3'b000,3'b000,0); checks++;
      if (obs !== exp_v) $display("FAIL random_idle%0d: got %h expected %h", b, obs, exp_v); else passes++;
      acc = 0; cyc = 0; accepted = 1'b0;
      while (acc <= len && cyc < 300) begin
        tick();
        get = 3'($urandom);
        out_ready = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
          len_val[i] = 4'($urandom);
          if (i != r || accepted) lane_val[i] = 8'($urandom);
        end
        smp();
        exp_v = mk(1,1,(acc == len),2'(r),lane_val[r],out_ready ? hot : 3'b000,3'b000,0); checks++;
        if (obs !== exp_v) $display("FAIL random_beat%0d_%0d: got %h expected %h", b, cyc, obs, exp_v); else passes++;
        accepted = out_ready;
        if (out_ready) acc++;
        cyc++;
      end
      if (cyc >= 300) begin
        checks++;
        $display("FAIL random_timeout%0d: got %0d beats expected %0d", b, acc, len + 1);
        return;
      end
      tick(); get = 3'($urandom); out_ready = 1'($urandom); smp();
      exp_v = mk(1,0,0,2'd0,8'h00,3'b000,hot,0); checks++;
      if (obs !== exp_v) $display("FAIL random_done%0d: got %h expected %h", b, obs, exp_v); else passes++;
      tick();
    end
    get = 3'b000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_rotation();
    test_grant_change();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
